// File: rtl/cdb_arbiter.sv
// cdb_arbiter: arbitrates ALU/MUL/DIV results onto one registered common data bus.
// Define CDB_RR_ARB_EN for round-robin grant; default is fixed priority DIV > MUL > ALU.
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              recover_en,
    input  logic              alu_done,
    input  logic              mul_valid_o,
    input  logic              div_valid_o,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mul_result,
    input  logic [DATA_W-1:0] div_result,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [TAG_W-1:0]  mul_tag,
    input  logic [TAG_W-1:0]  div_tag,
    output logic              alu_wb_ready,
    output logic              mul_wb_ready,
    output logic              div_wb_ready,
    input  logic              cdb_ready,
    output logic              cdb_valid,
    output logic [DATA_W-1:0] cdb_data,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [1:0]        cdb_src
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_data [3][DEPTH];
    logic [TAG_W-1:0]  r_tag  [3][DEPTH];
    logic [PW-1:0]     r_wptr [3];
    logic [PW-1:0]     r_rptr [3];
    logic [CW-1:0]     r_cnt  [3];

    logic [2:0]        w_valid;
    logic [DATA_W-1:0] w_din [3];
    logic [TAG_W-1:0]  w_tin [3];
    logic [3:0]        w_ne;
    logic [2:0]        w_ready;
    logic [2:0]        w_push;
    logic [2:0]        w_pop;
    logic [1:0]        w_gnt;
    logic              w_load;
    logic              w_any;

    assign w_valid = {div_valid_o, mul_valid_o, alu_done};
    assign w_din[0] = alu_result;
    assign w_din[1] = mul_result;
    assign w_din[2] = div_result;
    assign w_tin[0] = alu_tag;
    assign w_tin[1] = mul_tag;
    assign w_tin[2] = div_tag;
    assign alu_wb_ready = w_ready[0];
    assign mul_wb_ready = w_ready[1];
    assign div_wb_ready = w_ready[2];
    assign w_load = !cdb_valid || cdb_ready;
    assign w_any = |w_ne[2:0];

    // Ready comes only from registered counts, so a full FIFO stays not-ready even while it pops.
    always_comb begin
        w_ne = '0;
        w_ready = '0;
        w_push = '0;
        for (int s = 0; s < 3; s++) begin
            w_ne[s] = r_cnt[s] != '0;
            w_ready[s] = r_cnt[s] < CW'(DEPTH);
            w_push[s] = w_valid[s] && w_ready[s] && !recover_en;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int s = 0; s < 3; s++)
            w_pop[s] = w_load && !recover_en && w_ne[s] && (w_gnt == 2'(s));
    end

`ifdef CDB_RR_ARB_EN
    logic [1:0] r_rr_ptr;
    logic [1:0] w_c1;
    logic [1:0] w_c2;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign w_c1 = nxt(r_rr_ptr);
    assign w_c2 = nxt(w_c1);

    always_comb begin
        w_gnt = w_ne[w_c1] ? w_c1 : w_ne[w_c2] ? w_c2 : r_rr_ptr;
    end

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i)
            r_rr_ptr <= 2'd2;
        else if (|w_pop)
            r_rr_ptr <= w_gnt;
`else
    always_comb begin
        w_gnt = w_ne[2] ? 2'd2 : w_ne[1] ? 2'd1 : 2'd0;
    end
`endif

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            for (int s = 0; s < 3; s++) begin
                r_wptr[s] <= '0;
                r_rptr[s] <= '0;
                r_cnt[s] <= '0;
            end
        end else if (recover_en) begin
            for (int s = 0; s < 3; s++) begin
                r_wptr[s] <= '0;
                r_rptr[s] <= '0;
                r_cnt[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 3; s++) begin
                if (w_push[s])
                    r_wptr[s] <= r_wptr[s] + PW'(1);
                if (w_pop[s])
                    r_rptr[s] <= r_rptr[s] + PW'(1);
                r_cnt[s] <= r_cnt[s] + CW'(w_push[s]) - CW'(w_pop[s]);
            end
        end

    always_ff @(posedge clk_i)
        for (int s = 0; s < 3; s++)
            if (w_push[s]) begin
                r_data[s][r_wptr[s]] <= w_din[s];
                r_tag[s][r_wptr[s]] <= w_tin[s];
            end

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            cdb_valid <= 1'b0;
            cdb_data <= '0;
            cdb_tag <= '0;
            cdb_src <= 2'd0;
        end else if (recover_en) begin
            cdb_valid <= 1'b0;
            cdb_src <= 2'd0;
        end else if (w_load) begin
            if (w_any) begin
                cdb_valid <= 1'b1;
                cdb_data <= r_data[w_gnt][r_rptr[w_gnt]];
                cdb_tag <= r_tag[w_gnt][r_rptr[w_gnt]];
                cdb_src <= w_gnt + 2'd1;
            end else begin
                cdb_valid <= 1'b0;
                cdb_src <= 2'd0;
            end
        end
endmodule
